// File: rtl/vx_pe_deserializer.sv
// Gathers BATCH narrow PE-result beats into one full-width lane packet.
// Two ping-pong slots let one packet assemble while the other waits to drain.
module vx_pe_deserializer #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_PES    = 1,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [NUM_PES*DATA_WIDTH-1:0]   data_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  output logic                            ready_in,
  output logic                            valid_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  input  logic                            ready_out
);

  localparam int BATCH  = NUM_LANES / NUM_PES;
  localparam int IDX_W  = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int BEAT_W = NUM_PES * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH - 1);

  if (NUM_LANES % NUM_PES != 0) begin : g_bad_pes
    $error("vx_pe_deserializer: NUM_PES must divide NUM_LANES");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("vx_pe_deserializer: TAG_WIDTH must be at least 1");
  end

  // Beat k of a packet fills lanes k*NUM_PES .. k*NUM_PES+NUM_PES-1, i.e. chunk k.
  typedef logic [BATCH-1:0][BEAT_W-1:0] slot_t;

  slot_t                 slot_data_q [2];
  slot_t                 slot_data_d [2];
  logic [TAG_WIDTH-1:0]  slot_tag_q  [2];
  logic [TAG_WIDTH-1:0]  slot_tag_d  [2];
  logic [1:0]            full_q, full_d;
  logic                  wr_slot_q, wr_slot_d;
  logic                  rd_slot_q, rd_slot_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic                  accept_s;
  logic                  drain_s;

  // Next-state: beat write into the assembling slot, packet completion and drain.
  always_comb begin
    slot_data_d = slot_data_q;
    slot_tag_d  = slot_tag_q;
    full_d      = full_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    beat_idx_d  = beat_idx_q;
    accept_s    = valid_in & ~full_q[wr_slot_q];
    drain_s     = full_q[rd_slot_q] & ready_out;

    if (accept_s) begin
      for (int k = 0; k < BATCH; k++) begin
        if (beat_idx_q == IDX_W'(k)) begin
          slot_data_d[wr_slot_q][k] = data_in;
        end else begin
          slot_data_d[wr_slot_q][k] = slot_data_q[wr_slot_q][k];
        end
      end
      if (beat_idx_q == {IDX_W{1'b0}}) begin
        slot_tag_d[wr_slot_q] = tag_in;
      end else begin
        slot_tag_d[wr_slot_q] = slot_tag_q[wr_slot_q];
      end
      if (beat_idx_q == LAST_IDX) begin
        full_d[wr_slot_q] = 1'b1;
        wr_slot_d         = ~wr_slot_q;
        beat_idx_d        = {IDX_W{1'b0}};
      end else begin
        beat_idx_d        = beat_idx_q + IDX_W'(1);
      end
    end else begin
      beat_idx_d = beat_idx_q;
    end

    // The writing slot is never full, so this never collides with the set above.
    if (drain_s) begin
      full_d[rd_slot_q] = 1'b0;
      rd_slot_d         = ~rd_slot_q;
    end else begin
      rd_slot_d         = rd_slot_q;
    end
  end

  // State registers; reset discards any partial or waiting packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        slot_data_q[s] <= {(BATCH*BEAT_W){1'b0}};
        slot_tag_q[s]  <= {TAG_WIDTH{1'b0}};
      end
      full_q     <= 2'b00;
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      beat_idx_q <= {IDX_W{1'b0}};
    end else begin
      for (int s = 0; s < 2; s++) begin
        slot_data_q[s] <= slot_data_d[s];
        slot_tag_q[s]  <= slot_tag_d[s];
      end
      full_q     <= full_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  assign ready_in  = ~full_q[wr_slot_q];
  assign valid_out = full_q[rd_slot_q];
  assign data_out  = slot_data_q[rd_slot_q];
  assign tag_out   = slot_tag_q[rd_slot_q];

endmodule

// File: tb/tb_vx_pe_deserializer.sv
// Scoreboard bench for vx_pe_deserializer: the driver queues each completed
// packet's expected contents, a negedge monitor checks every output transfer.
module tb_vx_pe_deserializer;

  localparam int NL = 8;
  localparam int NP = 2;
  localparam int DW = 8;
  localparam int TW = 4;

  typedef struct packed {
    logic [NL*DW-1:0] d;
    logic [TW-1:0]    t;
  } pkt_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [NP*DW-1:0] data_in;
  logic [TW-1:0]    tag_in;
  logic             ready_in;
  logic             valid_out;
  logic [NL*DW-1:0] data_out;
  logic [TW-1:0]    tag_out;
  logic             ready_out;

  pkt_t sb[$];
  int   out_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   outs = 0;
  int   stall_cnt = 0;
  int   gap_pct = 0;
  bit   rand_ready = 1'b0;
  bit   held = 1'b0;
  logic [NL*DW-1:0] held_d;
  logic [TW-1:0]    held_t;

  vx_pe_deserializer #(
    .NUM_LANES(NL), .NUM_PES(NP), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .tag_in(tag_in), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .tag_out(tag_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_out = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: output transfers against the scoreboard, plus hold stability.
  always @(negedge clk) begin
    pkt_t e;
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!valid_out || data_out !== held_d || tag_out !== held_t) begin
          errors++;
          $display("FAIL stall_stable valid=%b data=%h tag=%h required valid=1 data=%h tag=%h",
                   valid_out, data_out, tag_out, held_d, held_t);
        end
      end
      if (valid_out && ready_out) begin
        outs++;
        out_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out data=%h tag=%h required no packet", data_out, tag_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || tag_out !== e.t) begin
            errors++;
            $display("FAIL packet data=%h tag=%h required data=%h tag=%h",
                     data_out, tag_out, e.d, e.t);
          end
        end
      end
      held   = valid_out && !ready_out;
      held_d = data_out;
      held_t = tag_out;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [7:0] base, input logic [TW-1:0] tag);
    pkt_t p;
    for (int l = 0; l < NL; l++) p.d[l*DW +: DW] = base + 8'(l);
    p.t = tag;
    return p;
  endfunction

  function automatic logic [NP*DW-1:0] mk_beat(input logic [7:0] base, input int k);
    logic [7:0] lo;
    lo = base + 8'(2*k);
    return {lo + 8'd1, lo};
  endfunction

  // Drives one beat until accepted; a last beat queues its packet's expectation.
  task automatic send_beat(input logic [NP*DW-1:0] d, input logic [TW-1:0] t,
                           input bit last, input pkt_t e);
    int tries = 0;
    bit acc = 1'b0;
    if (gap_pct > 0) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b1;
    data_in  = d;
    tag_in   = t;
    while (!acc) begin
      @(negedge clk);
      acc = ready_in;
      if (acc && last) sb.push_back(e);
      @(posedge clk); #1;
      tries++;
      if (!acc && tries > 500) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout ready_in=%b required 1 within 500 cycles", ready_in);
        valid_in = 1'b0;
        return;
      end
    end
    valid_in = 1'b0;
    stall_cnt += tries - 1;
  endtask

  task automatic send_packet(input logic [7:0] base, input logic [TW-1:0] tag, input int nbeats);
    pkt_t e;
    e = mk_pkt(base, tag);
    for (int k = 0; k < nbeats; k++)
      send_beat(mk_beat(base, k), (k == 0) ? tag : ~tag, k == 3, e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc_cnt;
    int outs_before;
    reset = 1'b0; valid_in = 1'b0; data_in = '0; tag_in = '0; ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd1);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_tag_out", 64'(tag_out), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single packet, hand-built beats and junk tags after beat 0.
    ready_out = 1'b1;
    send_beat(16'h0100, 4'h5, 1'b0, '0);
    send_beat(16'h0302, 4'hF, 1'b0, '0);
    send_beat(16'h0504, 4'hF, 1'b0, '0);
    send_beat(16'h0706, 4'hF, 1'b1, {64'h0706050403020100, 4'h5});
    @(negedge clk);
    chk("s1_valid", 64'(valid_out), 64'd1);
    chk("s1_data", data_out, 64'h0706050403020100);
    chk("s1_tag", 64'(tag_out), 64'd5);
    @(negedge clk);
    chk("s1_valid_once", 64'(valid_out), 64'd0);

    // Streaming: five back-to-back packets.
    @(posedge clk); #1;
    out_cyc.delete();
    stall_cnt = 0;
    for (int p = 0; p < 5; p++) send_packet(8'(8'h10 * (p + 1)), 4'(p + 1), 4);
    wait_drain();
    chk("s2_stalls", 64'(stall_cnt), 64'd0);
    chk("s2_outs", 64'(out_cyc.size()), 64'd5);
    for (int i = 1; i < out_cyc.size(); i++)
      chk("s2_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd4);

    // Backpressure: only two packets fit.
    ready_out = 1'b0;
    acc_cnt = 0;
    valid_in = 1'b1;
    for (int c = 0; c < 14; c++) begin
      int pk;
      int k;
      pk = acc_cnt / 4;
      k  = acc_cnt % 4;
      data_in = mk_beat(8'(8'h40 + pk * 8), k);
      tag_in  = (k == 0) ? 4'(6 + pk) : 4'hF;
      @(negedge clk);
      if (ready_in) begin
        acc_cnt++;
        if (k == 3) sb.push_back(mk_pkt(8'(8'h40 + pk * 8), 4'(6 + pk)));
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("s3_accepted", 64'(acc_cnt), 64'd8);
    chk("s3_ready_low", 64'(ready_in), 64'd0);
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
    @(negedge clk);
    chk("s3_ready_back", 64'(ready_in), 64'd1);
    chk("s3_valid_next", 64'(valid_out), 64'd1);
    chk("s3_tag_next", 64'(tag_out), 64'd7);
    ready_out = 1'b1;
    wait_drain();

    // Drain of one slot on the same edge the other slot completes.
    ready_out = 1'b0;
    send_packet(8'h80, 4'hA, 4);
    send_packet(8'h90, 4'hB, 3);
    ready_out = 1'b1;
    send_beat(mk_beat(8'h90, 3), 4'h4, 1'b1, mk_pkt(8'h90, 4'hB));
    ready_out = 1'b0;
    @(negedge clk);
    chk("s4_valid", 64'(valid_out), 64'd1);
    chk("s4_tag", 64'(tag_out), 64'hB);
    chk("s4_pending", 64'(sb.size()), 64'd1);
    ready_out = 1'b1;
    wait_drain();

    // Asynchronous reset with a full slot and a partial packet.
    ready_out = 1'b0;
    send_packet(8'hA0, 4'h3, 4);
    send_packet(8'hB0, 4'h4, 2);
    @(negedge clk);
    chk("s5_pre_valid", 64'(valid_out), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_valid", 64'(valid_out), 64'd0);
    chk("s5_ready", 64'(ready_in), 64'd1);
    chk("s5_data", data_out, 64'd0);
    chk("s5_tag", 64'(tag_out), 64'd0);
    sb.delete();
    held = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ready_out = 1'b1;
    send_packet(8'hC0, 4'h9, 4);
    wait_drain();

    // Random valid_in gaps and random ready_out.
    outs_before = outs;
    gap_pct = 50;
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) send_packet(8'(p * 8), 4'(p), 4);
    rand_ready = 1'b0;
    gap_pct = 0;
    @(posedge clk); #2;
    ready_out = 1'b1;
    wait_drain();
    chk("s6_outs", 64'(outs - outs_before), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
